// File: rtl/sha2_multi_out.sv
// Single-block SHA-256 engine for 3-byte messages: 64 rounds, one per clock, then the digest streams out as 8 words.
// Optional build macro SHA2_OUT_ZERO_EN forces msg_out to zero whenever ready is low.
module sha2_multi_out (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [23:0] msg_in,
    output logic [31:0] msg_out,
    output logic        ready
);

    typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

    localparam logic [31:0] H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state, state_next;
    logic        start;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w [16];
    logic [5:0]  t;
    logic [2:0]  word_idx;
    logic [31:0] digest [8];

    logic [31:0] big_s0, big_s1, ch, maj, t1, t2, a_new, e_new;
    logic [31:0] sml_s0, sml_s1, w_new;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    start      = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (t == 6'd63) state_next = OUT;
            end
            OUT: begin
                if (word_idx == 3'd7) begin
                    if (valid) begin
                        start      = 1'b1;
                        state_next = ROUND;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // w[0] is always W[t]; the window shifts down each round and w_new becomes W[t+16].
    always_comb begin
        big_s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
        ch     = (e & f) ^ (~e & g);
        t1     = h + big_s1 + ch + K[t] + w[0];
        big_s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
        maj    = (a & b) ^ (a & c) ^ (b & c);
        t2     = big_s0 + maj;
        a_new  = t1 + t2;
        e_new  = d + t1;
        sml_s0 = rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3);
        sml_s1 = rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10);
        w_new  = sml_s1 + w[9] + sml_s0 + w[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            t        <= 6'd0;
            word_idx <= 3'd0;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= 32'h0;
            for (int i = 0; i < 8; i++) digest[i] <= 32'h0;
        end else begin
            state <= state_next;
            if (start) begin
                {a, b, c, d} <= {H0[0], H0[1], H0[2], H0[3]};
                {e, f, g, h} <= {H0[4], H0[5], H0[6], H0[7]};
                w[0] <= {msg_in, 8'h80};
                for (int i = 1; i < 15; i++) w[i] <= 32'h0;
                w[15] <= 32'h00000018;
                t     <= 6'd0;
            end else if (state == ROUND) begin
                {b, c, d} <= {a, b, c};
                {f, g, h} <= {e, f, g};
                a <= a_new;
                e <= e_new;
                for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                w[15] <= w_new;
                t     <= t + 6'd1;
                if (t == 6'd63) begin
                    digest[0] <= H0[0] + a_new;
                    digest[1] <= H0[1] + a;
                    digest[2] <= H0[2] + b;
                    digest[3] <= H0[3] + c;
                    digest[4] <= H0[4] + e_new;
                    digest[5] <= H0[5] + e;
                    digest[6] <= H0[6] + f;
                    digest[7] <= H0[7] + g;
                    word_idx  <= 3'd0;
                end
            end else if (state == OUT) begin
                word_idx <= word_idx + 3'd1;
            end
        end
    end

    assign ready = (state == OUT);

    // Outside OUT the digest register still holds the previous result, so word 7 stays visible.
`ifdef SHA2_OUT_ZERO_EN
    assign msg_out = ready ? digest[word_idx] : 32'h0;
`else
    assign msg_out = ready ? digest[word_idx] : digest[7];
`endif

endmodule

// File: tb/tb_sha2_multi_out.sv
// Directed bench for sha2_multi_out: reset, "abc", a chained run of nine messages, idle return and reset mid-hash.
// Digests other than "abc" come from a straightforward full-schedule SHA-256 function in the bench.
module tb_sha2_multi_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [23:0] msg_in;
    logic [31:0] msg_out;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    localparam logic [31:0] H_TB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [23:0] msgs [9] = '{24'h000000, 24'hffffff, 24'hc3aa0f, 24'hff00ff, 24'h00ff00,
                              24'he21d55, 24'h7e81f5, 24'h696969, 24'hc33ccc};

    sha2_multi_out dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .msg_in  (msg_in),
        .msg_out (msg_out),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x} >> n;
        return xx[31:0];
    endfunction

    // Reference SHA-256 of one padded 3-byte block using the full 64-entry schedule.
    function automatic logic [255:0] sha_ref(input logic [23:0] m);
        logic [31:0] ww [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, tmp1, tmp2;
        for (int i = 0; i < 16; i++) ww[i] = 32'h0;
        ww[0]  = {m, 8'h80};
        ww[15] = 32'd24;
        for (int i = 16; i < 64; i++) begin
            s0 = ror(ww[i-15], 7) ^ ror(ww[i-15], 18) ^ (ww[i-15] >> 3);
            s1 = ror(ww[i-2], 17) ^ ror(ww[i-2], 19) ^ (ww[i-2] >> 10);
            ww[i] = ww[i-16] + s0 + ww[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = H_TB[i];
        for (int i = 0; i < 64; i++) begin
            s1   = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
            tmp1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[i] + ww[i];
            s0   = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
            tmp2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + tmp1;
            v[0] = tmp1 + tmp2;
        end
        return {H_TB[0] + v[0], H_TB[1] + v[1], H_TB[2] + v[2], H_TB[3] + v[3],
                H_TB[4] + v[4], H_TB[5] + v[5], H_TB[6] + v[6], H_TB[7] + v[7]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at the negedge where the capturing valid/msg_in are already applied; returns at the word-7 negedge
    // with the next request applied. Scrambles msg_in mid-ROUND to show the captured value is what gets hashed.
    task automatic run_hash(input string name, input logic [255:0] expected,
                            input logic [23:0] next_msg, input logic next_valid);
        int          cnt;
        logic [23:0] held;
        held = msg_in;
        cnt  = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 30) msg_in = ~held;
        end while (!ready && cnt < 200);
        check_output({name, " latency"}, cnt, 32'd65);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check_output($sformatf("%s ready%0d", name, i), {31'b0, ready}, 32'd1);
            check_output($sformatf("%s word%0d", name, i), msg_out, expected[255 - 32*i -: 32]);
        end
        msg_in = next_msg;
        valid  = next_valid;
    endtask

    initial begin
        logic [255:0] last_digest;
        logic [31:0]  hold_exp;
        int           ready_seen;

        rst    = 1'b1;
        valid  = 1'b0;
        msg_in = 24'h0;
        repeat (3) @(negedge clk);
        check_output("reset ready", {31'b0, ready}, 32'd0);
        check_output("reset msg_out", msg_out, 32'h0);

        $display("[TB] abc hash then nine chained messages");
        rst    = 1'b0;
        msg_in = 24'h616263;
        valid  = 1'b1;
        run_hash("abc", ABC_DIGEST, msgs[0], 1'b1);
        for (int k = 0; k < 9; k++) begin
            if (k < 8) run_hash($sformatf("chain%0d", k), sha_ref(msgs[k]), msgs[k+1], 1'b1);
            else       run_hash($sformatf("chain%0d", k), sha_ref(msgs[k]), 24'h0, 1'b0);
        end

        last_digest = sha_ref(msgs[8]);
`ifdef SHA2_OUT_ZERO_EN
        hold_exp = 32'h0;
`else
        hold_exp = last_digest[31:0];
`endif
        @(negedge clk);
        check_output("idle ready", {31'b0, ready}, 32'd0);
        check_output("idle msg_out", msg_out, hold_exp);
        ready_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ready) ready_seen++;
        end
        check_output("idle stays quiet", ready_seen, 32'd0);
        check_output("idle msg_out later", msg_out, hold_exp);

        $display("[TB] reset during ROUND");
        msg_in = 24'h616263;
        valid  = 1'b1;
        @(negedge clk);
        repeat (29) @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        check_output("midreset ready", {31'b0, ready}, 32'd0);
        check_output("midreset msg_out", msg_out, 32'h0);
        rst = 1'b0;
        ready_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (ready) ready_seen++;
        end
        check_output("post-reset idle", ready_seen, 32'd0);

        msg_in = 24'h616263;
        valid  = 1'b1;
        run_hash("abc2", ABC_DIGEST, 24'h0, 1'b0);
        @(negedge clk);
`ifdef SHA2_OUT_ZERO_EN
        hold_exp = 32'h0;
`else
        hold_exp = 32'hf20015ad;
`endif
        check_output("abc2 idle ready", {31'b0, ready}, 32'd0);
        check_output("abc2 hold msg_out", msg_out, hold_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
